// File: rtl/alu_ctrl.sv
// Byte-stream packet controller: echo, 32-bit add and 32-bit xor over a uart rx/tx pair.
// Define ALU_CTRL_ERR_RESP_EN to answer invalid packets with a single 0xEE byte.
module alu_ctrl #(
  parameter int MaxLen = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_tdata_i,
  input  logic       rx_tvalid_i,
  output logic       rx_tready_o,
  output logic [7:0] tx_tdata_o,
  output logic       tx_tvalid_o,
  input  logic       tx_tready_i,
  output logic       busy_o
);

  localparam logic [15:0] MaxLenW = 16'(MaxLen);
  localparam logic [7:0]  OpEcho  = 8'hEC;
  localparam logic [7:0]  OpAdd   = 8'hA0;
  localparam logic [7:0]  OpXor   = 8'hA1;
  localparam logic [7:0]  ErrByte = 8'hEE;

  typedef enum logic [2:0] {
    IDLE, HDR, ECHO_RX, ECHO_TX, OPER, SEND, DRAIN, ERR
  } state_e;

`ifdef ALU_CTRL_ERR_RESP_EN
  localparam state_e ErrExit = ERR;
`else
  localparam state_e ErrExit = IDLE;
`endif

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [23:0] opnd_q, opnd_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [1:0]  send_idx_q, send_idx_d;

  logic        rx_fire, tx_fire;
  logic [15:0] hdr_len, pay_len;
  logic        len_ok, words_ok, last_pay;
  logic [31:0] opnd_word, acc_new;

  // Outputs are forced quiet while reset is held, not just after the reset edge.
  assign rx_tready_o = !rst_i && (state_q inside {IDLE, HDR, ECHO_RX, OPER, DRAIN});
  assign tx_tvalid_o = !rst_i && (state_q inside {ECHO_TX, SEND, ERR});
  assign tx_tdata_o  = rst_i ? 8'h00 : ((state_q == ERR) ? ErrByte : tx_data_q);
  assign busy_o      = !rst_i && (state_q != IDLE);

  assign rx_fire   = rx_tvalid_i && rx_tready_o;
  assign tx_fire   = tx_tvalid_o && tx_tready_i;
  assign hdr_len   = {rx_tdata_i, len_q[7:0]};
  assign len_ok    = (hdr_len >= 16'd4) && (hdr_len <= MaxLenW);
  assign words_ok  = (hdr_len[1:0] == 2'b00) && (hdr_len != 16'd4);
  assign pay_len   = len_q - 16'd4;
  assign last_pay  = (cnt_q + 16'd1) == pay_len;
  // Little-endian assembly: each new byte enters at the top and shifts earlier ones down.
  assign opnd_word = {rx_tdata_i, opnd_q};
  assign acc_new   = (cnt_q[15:2] == 14'd0) ? opnd_word :
                     (opcode_q == OpAdd)    ? acc_q + opnd_word :
                                              acc_q ^ opnd_word;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    opcode_d   = opcode_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    tx_data_d  = tx_data_q;
    send_idx_d = send_idx_q;

    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          opcode_d = rx_tdata_i;
          cnt_d    = 16'd0;
          state_d  = HDR;
        end
      end
      HDR: begin
        // cnt_q indexes the header bytes after the opcode: reserved, length LSB, length MSB.
        if (rx_fire) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'd1) len_d[7:0] = rx_tdata_i;
          if (cnt_q == 16'd2) begin
            len_d = hdr_len;
            cnt_d = 16'd0;
            if (opcode_q == OpEcho && len_ok) begin
              state_d = (hdr_len == 16'd4) ? IDLE : ECHO_RX;
            end else if ((opcode_q == OpAdd || opcode_q == OpXor) && len_ok && words_ok) begin
              state_d = OPER;
            end else begin
              state_d = (hdr_len > 16'd4) ? DRAIN : ErrExit;
            end
          end
        end
      end
      ECHO_RX: begin
        if (rx_fire) begin
          tx_data_d = rx_tdata_i;
          cnt_d     = cnt_q + 16'd1;
          state_d   = ECHO_TX;
        end
      end
      ECHO_TX: begin
        if (tx_fire) state_d = (cnt_q == pay_len) ? IDLE : ECHO_RX;
      end
      OPER: begin
        if (rx_fire) begin
          cnt_d  = cnt_q + 16'd1;
          opnd_d = opnd_word[31:8];
          if (cnt_q[1:0] == 2'd3) acc_d = acc_new;
          if (last_pay) begin
            tx_data_d  = acc_new[7:0];
            send_idx_d = 2'd0;
            state_d    = SEND;
          end
        end
      end
      SEND: begin
        if (tx_fire) begin
          send_idx_d = send_idx_q + 2'd1;
          case (send_idx_q)
            2'd0:    tx_data_d = acc_q[15:8];
            2'd1:    tx_data_d = acc_q[23:16];
            default: tx_data_d = acc_q[31:24];
          endcase
          if (send_idx_q == 2'd3) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (rx_fire) begin
          cnt_d = cnt_q + 16'd1;
          if (last_pay) state_d = ErrExit;
        end
      end
      ERR: begin
        if (tx_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst_i) begin
      state_q    <= IDLE;
      opcode_q   <= 8'h00;
      len_q      <= 16'd0;
      cnt_q      <= 16'd0;
      acc_q      <= 32'd0;
      opnd_q     <= 24'd0;
      tx_data_q  <= 8'h00;
      send_idx_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      tx_data_q  <= tx_data_d;
      send_idx_q <= send_idx_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed packets with literal answers plus random packets
// scored by a packet-level model; follows ALU_CTRL_ERR_RESP_EN for invalid-packet expectations.
module tb_alu_ctrl;

  localparam int MaxLen = 64;

  typedef logic [7:0] bq_t[$];

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] rx_tdata_i = 8'h00;
  logic       rx_tvalid_i = 1'b0;
  logic       rx_tready_o;
  logic [7:0] tx_tdata_o;
  logic       tx_tvalid_o;
  logic       tx_tready_i = 1'b0;
  logic       busy_o;

  int   n_chk = 0;
  int   n_err = 0;
  bq_t  exp_q;
  logic tx_slow = 1'b0;
  int   slow_cnt = 0;

  alu_ctrl #(.MaxLen(MaxLen)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_tdata_i  (rx_tdata_i),
    .rx_tvalid_i (rx_tvalid_i),
    .rx_tready_o (rx_tready_o),
    .tx_tdata_o  (tx_tdata_o),
    .tx_tvalid_o (tx_tvalid_o),
    .tx_tready_i (tx_tready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Packet-level reference: what the controller must transmit for one whole packet.
  function automatic bq_t model(input bq_t p);
    bq_t         r;
    int          len;
    logic [7:0]  op;
    logic        ok;
    logic [31:0] acc, w;
    op  = p[0];
    len = int'({p[3], p[2]});
    ok  = (len >= 4) && (len <= MaxLen);
    if (op == 8'hA0 || op == 8'hA1) ok = ok && (len > 4) && (((len - 4) % 4) == 0);
    else if (op != 8'hEC) ok = 1'b0;
    if (!ok) begin
`ifdef ALU_CTRL_ERR_RESP_EN
      r.push_back(8'hEE);
`endif
      return r;
    end
    if (op == 8'hEC) begin
      for (int i = 4; i < len; i++) r.push_back(p[i]);
    end else begin
      acc = 32'd0;
      for (int k = 0; k < (len - 4) / 4; k++) begin
        w = {p[4*k+7], p[4*k+6], p[4*k+5], p[4*k+4]};
        if (k == 0) acc = w;
        else if (op == 8'hA0) acc = acc + w;
        else acc = acc ^ w;
      end
      for (int b = 0; b < 4; b++) r.push_back(acc[8*b +: 8]);
    end
    return r;
  endfunction

  function automatic bq_t gen_pkt();
    bq_t        p;
    int         kind, len, sel;
    logic [7:0] op;
    kind = int'($urandom_range(0, 5));
    op   = 8'hEC;
    len  = 4;
    case (kind)
      0: len = 4 + int'($urandom_range(0, 12));
      1: begin
        op  = ($urandom_range(0, 1) != 0) ? 8'hA0 : 8'hA1;
        len = 4 + 4 * int'($urandom_range(1, 4));
      end
      2: begin
        do op = 8'($urandom); while (op == 8'hEC || op == 8'hA0 || op == 8'hA1);
        len = 4 + int'($urandom_range(0, 6));
      end
      3: begin
        op  = ($urandom_range(0, 1) != 0) ? 8'hA0 : 8'hA1;
        len = 5 + int'($urandom_range(0, 10));
        if ((len % 4) == 0) len++;
      end
      4: begin
        sel = int'($urandom_range(0, 2));
        op  = (sel == 0) ? 8'hEC : (sel == 1) ? 8'hA0 : 8'hA1;
        len = int'($urandom_range(0, 3));
      end
      default: begin
        op  = ($urandom_range(0, 1) != 0) ? 8'hEC : 8'hA0;
        len = MaxLen + int'($urandom_range(0, 1));
      end
    endcase
    p.push_back(op);
    p.push_back(8'($urandom));
    p.push_back(8'(len));
    p.push_back(8'(len >> 8));
    for (int i = 4; i < len; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  // All driving tasks start and end just after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    int gap;
    gap = int'($urandom_range(0, 2));
    repeat (gap) begin
      @(posedge clk_i);
      #1;
    end
    rx_tdata_i  = b;
    rx_tvalid_i = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk_i);
      if (rx_tready_o) begin
        @(posedge clk_i);
        #1;
        rx_tvalid_i = 1'b0;
        return;
      end
      @(posedge clk_i);
      #1;
    end
    rx_tvalid_i = 1'b0;
    check("rx_accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk_i);
      if (!busy_o && exp_q.size() == 0) break;
      @(posedge clk_i);
      #1;
    end
    check("pkt_end_busy", 32'(busy_o), 32'd0);
    check("pkt_end_pending_tx", 32'(exp_q.size()), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_pkt(input bq_t pkt, input bq_t exp);
    foreach (exp[i]) exp_q.push_back(exp[i]);
    foreach (pkt[i]) send_byte(pkt[i]);
    wait_idle();
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check("rst_rx_tready", 32'(rx_tready_o), 32'd0);
    check("rst_tx_tvalid", 32'(tx_tvalid_o), 32'd0);
    check("rst_tx_tdata", 32'(tx_tdata_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_rx_tready", 32'(rx_tready_o), 32'd1);
    check("post_rst_busy", 32'(busy_o), 32'd0);
    check("post_rst_tx_tvalid", 32'(tx_tvalid_o), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  // tx sink: random back-pressure, or a 10-cycle hold-off per byte in slow mode.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (!tx_slow) begin
        tx_tready_i = ($urandom_range(0, 3) != 0);
      end else if (tx_tready_i) begin
        tx_tready_i = 1'b0;
        slow_cnt    = 0;
      end else if (tx_tvalid_o) begin
        if (slow_cnt >= 10) tx_tready_i = 1'b1;
        else slow_cnt++;
      end else begin
        slow_cnt = 0;
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  initial begin
    logic       prev_v, prev_r;
    logic [7:0] prev_d, want;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_d = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_v = 1'b0;
      end else begin
        check("rx_tx_exclusive", 32'(rx_tready_o & tx_tvalid_o), 32'd0);
        if (tx_tvalid_o) check("busy_while_tx", 32'(busy_o), 32'd1);
        if (prev_v && !prev_r) begin
          check("tx_hold_valid", 32'(tx_tvalid_o), 32'd1);
          check("tx_hold_data", 32'(tx_tdata_o), 32'(prev_d));
        end
        if (tx_tvalid_o && tx_tready_i) begin
          if (exp_q.size() == 0) begin
            check("tx_unexpected_byte", 32'(tx_tdata_o), 32'h100);
          end else begin
            want = exp_q.pop_front();
            check("tx_data", 32'(tx_tdata_o), 32'(want));
          end
        end
        prev_v = tx_tvalid_o;
        prev_r = tx_tready_i;
        prev_d = tx_tdata_o;
      end
    end
  end

  initial begin
    bq_t  err_exp;
    bq_t  none;
    bq_t  p;
    logic seen;
`ifdef ALU_CTRL_ERR_RESP_EN
    err_exp.push_back(8'hEE);
`endif

    apply_reset();

    run_pkt('{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43}, '{8'h41, 8'h42, 8'h43});
    run_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00},
            '{8'h01, 8'h00, 8'h00, 8'h00});
    run_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h11, 8'h11, 8'h11, 8'h11},
            '{8'h89, 8'h67, 8'h45, 8'h23});

    tx_slow = 1'b1;
    run_pkt('{8'hA1, 8'h00, 8'h10, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00});
    tx_slow = 1'b0;

    run_pkt('{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB}, err_exp);
    run_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A}, '{8'h5A});
    run_pkt('{8'hA0, 8'h00, 8'h09, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, err_exp);
    run_pkt('{8'hEC, 8'h00, 8'h04, 8'h00}, none);
    run_pkt('{8'hEC, 8'h00, 8'h02, 8'h00}, err_exp);
    run_pkt('{8'hA1, 8'h00, 8'h04, 8'h00}, err_exp);

    // Reset mid-packet: nothing may be transmitted, then a fresh add works.
    p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22};
    foreach (p[i]) send_byte(p[i]);
    apply_reset();
    run_pkt('{8'hA0, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00}, '{8'h05, 8'h00, 8'h00, 8'h00});

    // Reset mid-transmit while the sink is holding off.
    tx_slow = 1'b1;
    p = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    foreach (p[i]) send_byte(p[i]);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk_i);
      seen = tx_tvalid_o;
      @(posedge clk_i);
      #1;
    end
    check("send_started", 32'(seen), 32'd1);
    apply_reset();
    tx_slow = 1'b0;

    for (int n = 0; n < 40; n++) begin
      p = gen_pkt();
      run_pkt(p, model(p));
    end

    repeat (5) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
